laser_ctrl: RTL and testbench
=============================

# laser_ctrl

Ship projectile engine for the asteroid playfield: turns fire-button presses into up to MAX_SHOTS laser bolts launched from the ship nose. Bolts advance once per frame on the `move` strobe, are drawn into the pixel mux via `draw_laser`, and die on reaching the top wall or hitting an asteroid pixel. Sits between the spaceship and asteroid stages and the score counter. Per-frame hit counts drive score increments.

## Interface
Parameters:
- MAX_SHOTS, 4: number of bolt slots (1..8).
- LASER_W, 2: bolt width in pixels.
- LASER_H, 8: bolt height in pixels.
- SPEED, 6: pixels a bolt moves up per frame.
- TOP_LIMIT, 10: playfield top edge; matches the wall at vcount < 10.
- COOLDOWN, 8: frames between accepted shots.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  reset, asynchronous, active-low.
- pixpulse  in  1  25 MHz pixel enable, one clk wide.
- hcount  in  10  current pixel x.
- vcount  in  10  current pixel y.
- move  in  1  frame strobe, one clk wide, at vblank start.
- fire  in  1  raw fire button (btnC), asynchronous.
- ship_x  in  10  ship nose x (centre).
- ship_y  in  10  ship nose y (top).
- hit_target  in  1  asteroid pixel present at (hcount, vcount).
- draw_laser  out  1  a bolt covers the current pixel.
- hit_pulse  out  1  one clk; at least one bolt hit this frame.
- hit_count  out  4  number of bolts that hit; valid while hit_pulse = 1.
- active  out  MAX_SHOTS  slot occupancy flags.

## Operation
- `fire` passes through a 2-FF synchronizer, then a rising-edge detector. A detected edge sets `pending`.
- Each slot i holds: `act`, `x[9:0]`, `y[9:0]`, `hitf`.
- Collision scan: on a clk with pixpulse = 1, for each active slot covering (hcount, vcount) with hit_target = 1, set `hitf[i]`.
- Coverage test: act & x ≤ hcount < x+LASER_W & y ≤ vcount < y+LASER_H.
- `draw_laser` is the combinational OR of coverage over all slots.
- On `move`, apply these steps in order within one clk:
  1. Kill: every slot with `hitf` = 1 → act = 0, hitf = 0. hit_count = number killed; hit_pulse = 1 if hit_count ≠ 0.
  2. Advance: surviving active slots with y < TOP_LIMIT+SPEED → act = 0. Otherwise y ← y − SPEED. x is unchanged.
  3. Spawn: only if pending = 1, cooldown = 0, and ship_y ≥ TOP_LIMIT+LASER_H. Take the lowest-index slot free after steps 1–2 (a slot freed this frame is reusable). Set x = ship_x − LASER_W/2, y = ship_y − LASER_H, act = 1, and load cooldown = COOLDOWN. The new bolt is not advanced this frame.
  4. If cooldown ≠ 0 and no spawn occurred → cooldown decrements.
  5. pending ← 0. A fire is dropped if refused for any reason: cooldown, no free slot, or ship too high.
- A fire edge on the same clk as `move` sets pending after that clk's clear. It is serviced at the next move.
- All arithmetic is unsigned 10-bit. The spawn guards above prevent underflow.
- `active` mirrors `act` directly.

## Timing
- Reset (rst = 0) asynchronously clears: all slots (act, hitf, x, y = 0), cooldown = 0, pending = 0, synchronizer and edge registers = 0, hit_pulse = 0, hit_count = 0. draw_laser is therefore 0.
- Reset is independent of pixpulse and of any frame in progress. Mid-frame reset drops all bolts and any pending fire.
- Fire latency: button edge to pending takes 3 clk (2 sync + edge detect). Pending to bolt visible: the next move, then the next active frame.
- hit_pulse and hit_count are registered. They are valid on the clk after `move`, for exactly 1 clk; hit_count is 0 otherwise.
- Slot state updates only on move clks. hitf updates only on pixpulse clks.
- draw_laser has zero-cycle latency from hcount/vcount, the same as the other draw signals. The top-level pixel register absorbs it.

## Test plan
- Reset: hold rst = 0 with fire toggling → active = 0, draw_laser = 0, hit_pulse = 0. Release rst, press fire, ship_x = 375, ship_y = 440 → after the next move, slot 0 is at x = 374, y = 432; draw_laser = 1 exactly over hcount 374..375 × vcount 432..439.
- Motion/expiry: single bolt spawned at y = 432, no targets → y = 426, 420, … per move. The bolt deactivates on the move where y < 16; it is never drawn at vcount < 10.
- Cooldown: fire before every move for 20 frames → spawns on moves 1, 10, 19 (COOLDOWN = 8). All other fires are dropped.
- Slot exhaustion: set COOLDOWN = 0 and fire every frame → active fills to 4'b1111. A 5th fire is dropped. Expire slot 0 by top limit → the next fire occupies slot 0.
- Collision: hold hit_target = 1 over a 16×16 box at (370..385, 300..315) while two bolts pass through it → on the next move, both slots clear, hit_pulse = 1 for 1 clk, and hit_count = 2.
- Edge cases: fire asserted on the same clk as move → serviced at the following move, not the current one. Pulse rst mid-frame with 3 bolts active → all cleared and no hit_pulse afterward.

Source files
------------

// File: rtl/laser_ctrl_if.sv
// rtl/laser_ctrl_if.sv - pixel/frame/ship bus between the video pipeline and laser_ctrl
//
// Purpose: bundles the raster position, frame strobe, fire button, ship nose
// position and collision input towards laser_ctrl, and the draw/score outputs
// back from it.
// Ports (signals):
//   pixpulse, hcount[9:0], vcount[9:0], move, fire, ship_x[9:0], ship_y[9:0],
//   hit_target                            -> towards laser_ctrl
//   draw_laser, hit_pulse, hit_count[3:0],
//   active[MAX_SHOTS-1:0]                 <- from laser_ctrl
// Modports: master (video/game side), slave (laser_ctrl).
interface laser_ctrl_if #(
  parameter int MAX_SHOTS = 4
) ();
  logic                 pixpulse;
  logic [9:0]           hcount;
  logic [9:0]           vcount;
  logic                 move;
  logic                 fire;
  logic [9:0]           ship_x;
  logic [9:0]           ship_y;
  logic                 hit_target;
  logic                 draw_laser;
  logic                 hit_pulse;
  logic [3:0]           hit_count;
  logic [MAX_SHOTS-1:0] active;

  modport master (
    output pixpulse, hcount, vcount, move, fire, ship_x, ship_y, hit_target,
    input  draw_laser, hit_pulse, hit_count, active
  );

  modport slave (
    input  pixpulse, hcount, vcount, move, fire, ship_x, ship_y, hit_target,
    output draw_laser, hit_pulse, hit_count, active
  );
endinterface

// File: rtl/laser_ctrl.sv
// rtl/laser_ctrl.sv - ship laser bolt engine: spawn, per-frame motion, collision and hit counting
//
// Purpose: turns fire-button edges into up to MAX_SHOTS bolts launched from the
// ship nose, moves them up SPEED pixels on every move strobe, draws them into
// the pixel mux and retires them on the top wall or on an asteroid hit.
// Ports:
//   clk  - 100 MHz system clock
//   rst  - asynchronous active-low reset
//   bus  - laser_ctrl_if.slave: raster position, pixpulse, move, fire, ship
//          nose, hit_target in; draw_laser, hit_pulse, hit_count, active out
module laser_ctrl #(
  parameter int MAX_SHOTS = 4,
  parameter int LASER_W   = 2,
  parameter int LASER_H   = 8,
  parameter int SPEED     = 6,
  parameter int TOP_LIMIT = 10,
  parameter int COOLDOWN  = 8
) (
  input  logic         clk,
  input  logic         rst,
  laser_ctrl_if.slave  bus
);

  // +2 keeps the counter at least one bit wide even when COOLDOWN is 0.
  localparam int              CD_W       = $clog2(COOLDOWN + 2);
  localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(COOLDOWN);
  localparam logic [9:0]      MIN_Y_ADV  = 10'(TOP_LIMIT + SPEED);
  localparam logic [9:0]      MIN_SHIP_Y = 10'(TOP_LIMIT + LASER_H);
  localparam logic [9:0]      HALF_W     = 10'(LASER_W / 2);
  localparam logic [9:0]      SPEED_V    = 10'(SPEED);
  localparam logic [9:0]      HEIGHT_V   = 10'(LASER_H);

  logic                 fire_meta_q, fire_sync_q, fire_prev_q;
  logic                 fire_edge;
  logic                 pending_q, pending_d;
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [MAX_SHOTS-1:0] act_q, act_d;
  logic [MAX_SHOTS-1:0] hitf_q, hitf_d;
  logic [9:0]           x_q [MAX_SHOTS];
  logic [9:0]           x_d [MAX_SHOTS];
  logic [9:0]           y_q [MAX_SHOTS];
  logic [9:0]           y_d [MAX_SHOTS];
  logic                 hit_pulse_q, hit_pulse_d;
  logic [3:0]           hit_count_q, hit_count_d;
  logic [MAX_SHOTS-1:0] cov;
  logic [3:0]           kill_cnt;
  logic                 slot_found;

  assign fire_edge = fire_sync_q & ~fire_prev_q;

  // Per-slot pixel coverage; compared in 11 bits so x+LASER_W cannot wrap.
  always_comb begin
    cov = '0;
    for (int i = 0; i < MAX_SHOTS; i++) begin
      cov[i] = act_q[i]
             && ({1'b0, bus.hcount} >= {1'b0, x_q[i]})
             && ({1'b0, bus.hcount} <  ({1'b0, x_q[i]} + 11'(LASER_W)))
             && ({1'b0, bus.vcount} >= {1'b0, y_q[i]})
             && ({1'b0, bus.vcount} <  ({1'b0, y_q[i]} + 11'(LASER_H)));
    end
  end

  assign bus.draw_laser = |cov;
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.active     = act_q;

  always_comb begin
    act_d       = act_q;
    hitf_d      = hitf_q;
    x_d         = x_q;
    y_d         = y_q;
    cd_d        = cd_q;
    pending_d   = pending_q | fire_edge;
    hit_pulse_d = 1'b0;
    hit_count_d = '0;
    kill_cnt    = '0;
    slot_found  = 1'b0;

    if (bus.pixpulse) begin
      for (int i = 0; i < MAX_SHOTS; i++) begin
        if (cov[i] && bus.hit_target) hitf_d[i] = 1'b1;
      end
    end

    // The move block runs after the scan so a kill or expiry always wins
    // over a hit flag raised on the same clk.
    if (bus.move) begin
      for (int i = 0; i < MAX_SHOTS; i++) begin
        if (hitf_q[i]) begin
          act_d[i]  = 1'b0;
          hitf_d[i] = 1'b0;
          kill_cnt  = kill_cnt + 4'd1;
        end else if (act_q[i]) begin
          if (y_q[i] < MIN_Y_ADV) begin
            act_d[i]  = 1'b0;
            hitf_d[i] = 1'b0;
          end else begin
            y_d[i] = y_q[i] - SPEED_V;
          end
        end
      end
      hit_count_d = kill_cnt;
      hit_pulse_d = (kill_cnt != 4'd0);

      // Free-slot search looks at act_d so slots freed above are reusable.
      if (pending_q && (cd_q == '0) && (bus.ship_y >= MIN_SHIP_Y)) begin
        for (int i = 0; i < MAX_SHOTS; i++) begin
          if (!slot_found && !act_d[i]) begin
            slot_found = 1'b1;
            act_d[i]   = 1'b1;
            hitf_d[i]  = 1'b0;
            x_d[i]     = bus.ship_x - HALF_W;
            y_d[i]     = bus.ship_y - HEIGHT_V;
          end
        end
      end

      if (slot_found)          cd_d = CD_LOAD;
      else if (cd_q != '0)     cd_d = cd_q - CD_W'(1);

      // Refused fires are dropped; an edge on this very clk survives the clear.
      pending_d = fire_edge;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_meta_q <= 1'b0;
      fire_sync_q <= 1'b0;
      fire_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      cd_q        <= '0;
      act_q       <= '0;
      hitf_q      <= '0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
      for (int i = 0; i < MAX_SHOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      fire_meta_q <= bus.fire;
      fire_sync_q <= fire_meta_q;
      fire_prev_q <= fire_sync_q;
      pending_q   <= pending_d;
      cd_q        <= cd_d;
      act_q       <= act_d;
      hitf_q      <= hitf_d;
      hit_pulse_q <= hit_pulse_d;
      hit_count_q <= hit_count_d;
      for (int i = 0; i < MAX_SHOTS; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

endmodule

// File: tb/tb_laser_ctrl.sv
// tb/tb_laser_ctrl.sv - directed self-checking bench for laser_ctrl
module tb_laser_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pixpulse = 1'b0;
  logic       move = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [9:0] ship_x = 10'd375;
  logic [9:0] ship_y = 10'd440;
  logic       box_en = 1'b0;
  logic [9:0] box_x0 = 10'd370;
  logic [9:0] box_y0 = 10'd300;
  logic       hit_t;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 16x16 asteroid box seen by both DUTs.
  assign hit_t = box_en && (hcount >= box_x0) && (hcount <= box_x0 + 10'd15)
                        && (vcount >= box_y0) && (vcount <= box_y0 + 10'd15);

  laser_ctrl_if #(.MAX_SHOTS(4)) ifa ();
  laser_ctrl_if #(.MAX_SHOTS(4)) ifb ();

  assign ifa.pixpulse = pixpulse;  assign ifb.pixpulse = pixpulse;
  assign ifa.hcount = hcount;      assign ifb.hcount = hcount;
  assign ifa.vcount = vcount;      assign ifb.vcount = vcount;
  assign ifa.move = move;          assign ifb.move = move;
  assign ifa.fire = fire;          assign ifb.fire = fire;
  assign ifa.ship_x = ship_x;      assign ifb.ship_x = ship_x;
  assign ifa.ship_y = ship_y;      assign ifb.ship_y = ship_y;
  assign ifa.hit_target = hit_t;   assign ifb.hit_target = hit_t;

  laser_ctrl #(.MAX_SHOTS(4), .LASER_W(2), .LASER_H(8), .SPEED(6), .TOP_LIMIT(10), .COOLDOWN(8))
    u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  laser_ctrl #(.MAX_SHOTS(4), .LASER_W(2), .LASER_H(8), .SPEED(6), .TOP_LIMIT(10), .COOLDOWN(0))
    u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic do_move();
    @(negedge clk); move = 1'b1;
    @(negedge clk); move = 1'b0;
  endtask

  task automatic press_fire();
    @(negedge clk); fire = 1'b1;
    repeat (4) @(negedge clk);
    fire = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic probe(input logic [9:0] h, input logic [9:0] v, output logic da, output logic db);
    @(negedge clk);
    hcount = h; vcount = v;
    #1;
    da = ifa.draw_laser;
    db = ifb.draw_laser;
  endtask

  task automatic test_reset();
    logic da, db;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); fire = ~fire;
    end
    fire = 1'b0;
    probe(10'd374, 10'd432, da, db);
    n_checks++; if (ifa.active !== 4'b0000) begin n_fail++; $display("FAIL reset_active got=%b exp=0000", ifa.active); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL reset_draw got=%b exp=0", da); end
    n_checks++; if (ifa.hit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_hit_pulse got=%b exp=0", ifa.hit_pulse); end
    n_checks++; if (ifa.hit_count !== 4'd0) begin n_fail++; $display("FAIL reset_hit_count got=%0d exp=0", ifa.hit_count); end
    @(negedge clk); rst = 1'b1;
    ship_x = 10'd375; ship_y = 10'd440;
    press_fire();
    do_move();
    n_checks++; if (ifa.active !== 4'b0001) begin n_fail++; $display("FAIL spawn_active got=%b exp=0001", ifa.active); end
    begin
      logic [9:0] ph [8];
      logic [9:0] pv [8];
      logic       pe [8];
      ph = '{10'd374, 10'd375, 10'd374, 10'd375, 10'd373, 10'd376, 10'd374, 10'd374};
      pv = '{10'd432, 10'd432, 10'd439, 10'd439, 10'd432, 10'd432, 10'd431, 10'd440};
      pe = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
      for (int i = 0; i < 8; i++) begin
        probe(ph[i], pv[i], da, db);
        n_checks++;
        if (da !== pe[i]) begin
          n_fail++; $display("FAIL spawn_draw(%0d,%0d) got=%b exp=%b", ph[i], pv[i], da, pe[i]);
        end
      end
    end
  endtask

  task automatic test_motion();
    logic da, db;
    int   y;
    for (int k = 1; k <= 70; k++) begin
      do_move();
      y = 432 - 6 * k;
      n_checks++; if (ifa.active !== 4'b0001) begin n_fail++; $display("FAIL motion_active k=%0d got=%b exp=0001", k, ifa.active); end
      if (k == 1 || k == 2 || k == 35 || k == 70) begin
        probe(10'd374, 10'(y), da, db);
        n_checks++; if (da !== 1'b1) begin n_fail++; $display("FAIL motion_top k=%0d got=%b exp=1", k, da); end
        probe(10'd374, 10'(y - 1), da, db);
        n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL motion_above k=%0d got=%b exp=0", k, da); end
        probe(10'd374, 10'(y + 8), da, db);
        n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL motion_below k=%0d got=%b exp=0", k, da); end
      end
    end
    do_move();
    n_checks++; if (ifa.active !== 4'b0000) begin n_fail++; $display("FAIL expiry_active got=%b exp=0000", ifa.active); end
    probe(10'd374, 10'd12, da, db);
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL expiry_draw got=%b exp=0", da); end
  endtask

  task automatic test_cooldown();
    logic [3:0] exp_act;
    apply_reset();
    ship_x = 10'd375; ship_y = 10'd440;
    for (int m = 1; m <= 20; m++) begin
      press_fire();
      do_move();
      exp_act = (m >= 19) ? 4'b0111 : (m >= 10) ? 4'b0011 : 4'b0001;
      n_checks++;
      if (ifa.active !== exp_act) begin
        n_fail++; $display("FAIL cooldown_move%0d got=%b exp=%b", m, ifa.active, exp_act);
      end
    end
  endtask

  task automatic test_slot_exhaustion();
    logic da, db;
    logic [3:0] exp_b [7];
    exp_b = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1110, 4'b1111};
    apply_reset();
    ship_x = 10'd375;
    for (int m = 1; m <= 7; m++) begin
      ship_y = (m == 1) ? 10'd46 : 10'd440;
      if (m != 6) press_fire();
      do_move();
      n_checks++;
      if (ifb.active !== exp_b[m-1]) begin
        n_fail++; $display("FAIL slots_move%0d got=%b exp=%b", m, ifb.active, exp_b[m-1]);
      end
    end
    probe(10'd374, 10'd439, da, db);
    n_checks++; if (db !== 1'b1) begin n_fail++; $display("FAIL slots_reuse_draw got=%b exp=1", db); end
  endtask

  task automatic test_collision();
    apply_reset();
    ship_y = 10'd440;
    ship_x = 10'd375; press_fire(); do_move();
    ship_x = 10'd380; press_fire(); do_move();
    repeat (20) do_move();
    n_checks++; if (ifb.active !== 4'b0011) begin n_fail++; $display("FAIL coll_pre_active got=%b exp=0011", ifb.active); end
    box_x0 = 10'd370; box_y0 = 10'd300; box_en = 1'b1;
    for (int v = 296; v <= 323; v++) begin
      for (int h = 366; h <= 389; h++) begin
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); pixpulse = 1'b1;
      end
    end
    @(negedge clk); pixpulse = 1'b0; box_en = 1'b0;
    n_checks++; if (ifb.active !== 4'b0011) begin n_fail++; $display("FAIL coll_scan_active got=%b exp=0011", ifb.active); end
    do_move();
    n_checks++; if (ifb.hit_pulse !== 1'b1) begin n_fail++; $display("FAIL coll_hit_pulse got=%b exp=1", ifb.hit_pulse); end
    n_checks++; if (ifb.hit_count !== 4'd2) begin n_fail++; $display("FAIL coll_hit_count got=%0d exp=2", ifb.hit_count); end
    n_checks++; if (ifb.active !== 4'b0000) begin n_fail++; $display("FAIL coll_active got=%b exp=0000", ifb.active); end
    @(negedge clk);
    n_checks++; if (ifb.hit_pulse !== 1'b0) begin n_fail++; $display("FAIL coll_pulse_width got=%b exp=0", ifb.hit_pulse); end
    n_checks++; if (ifb.hit_count !== 4'd0) begin n_fail++; $display("FAIL coll_count_clear got=%0d exp=0", ifb.hit_count); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ship_x = 10'd375; ship_y = 10'd440;
    @(negedge clk); fire = 1'b1;
    @(negedge clk);
    @(negedge clk); move = 1'b1;
    @(negedge clk); move = 1'b0;
    n_checks++; if (ifa.active !== 4'b0000) begin n_fail++; $display("FAIL same_clk_fire_now got=%b exp=0000", ifa.active); end
    fire = 1'b0;
    repeat (3) @(negedge clk);
    do_move();
    n_checks++; if (ifa.active !== 4'b0001) begin n_fail++; $display("FAIL same_clk_fire_next got=%b exp=0001", ifa.active); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    ship_x = 10'd375; ship_y = 10'd440;
    repeat (3) begin press_fire(); do_move(); end
    n_checks++; if (ifb.active !== 4'b0111) begin n_fail++; $display("FAIL midrst_pre got=%b exp=0111", ifb.active); end
    box_x0 = 10'd370; box_y0 = 10'd420; box_en = 1'b1;
    for (int v = 420; v <= 427; v++) begin
      for (int h = 372; h <= 377; h++) begin
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); pixpulse = 1'b1;
      end
    end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (ifb.active !== 4'b0000) begin n_fail++; $display("FAIL midrst_async got=%b exp=0000", ifb.active); end
    @(negedge clk); rst = 1'b1; pixpulse = 1'b0; box_en = 1'b0;
    do_move();
    n_checks++; if (ifb.hit_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_hit_pulse got=%b exp=0", ifb.hit_pulse); end
    n_checks++; if (ifb.hit_count !== 4'd0) begin n_fail++; $display("FAIL midrst_hit_count got=%0d exp=0", ifb.hit_count); end
    n_checks++; if (ifb.active !== 4'b0000) begin n_fail++; $display("FAIL midrst_active got=%b exp=0000", ifb.active); end
  endtask

  initial begin
    test_reset();
    test_motion();
    test_cooldown();
    test_slot_exhaustion();
    test_collision();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
